// File: rtl/adc_capture.sv
`default_nettype none
// ============================================================================
// Module : adc_capture
// Reads the ADC after each EOC falling edge and buffers words in a FWFT FIFO.
// Optional EOC watchdog is compiled in when ADC_TIMEOUT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module adc_capture #(
   parameter int DATA_W         = 8,
   parameter int OE_CYCLES      = 2,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              eoc,
   input  logic [DATA_W-1:0] adc_data,
   input  logic              start,
   input  logic              flag_clr,
   output logic              adc_oe_n,
   output logic [DATA_W-1:0] sample_data,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic              overflow,
   output logic              timeout
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_READ = 1'b1
   } state_t;

   logic              s1_q, s2_q, s2_dly_q, eoc_fall_q;
   state_t            state_q;
   logic [3:0]        oe_cnt_q;
   logic              adc_oe_n_q;
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q;
   logic              overflow_q;

   logic              push_w, pop_w, full_w, wr_en_w;
   logic              read_ovf_w, fifo_ovf_w;

   // The edge pulse is registered so the read sequence starts three edges
   // after EOC is first sampled low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q       <= 1'b1;
         s2_q       <= 1'b1;
         s2_dly_q   <= 1'b1;
         eoc_fall_q <= 1'b0;
      end else begin
         s1_q       <= eoc;
         s2_q       <= s1_q;
         s2_dly_q   <= s2_q;
         eoc_fall_q <= s2_dly_q & ~s2_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         oe_cnt_q   <= '0;
         adc_oe_n_q <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (eoc_fall_q) begin
                  state_q    <= ST_READ;
                  oe_cnt_q   <= 4'(OE_CYCLES - 1);
                  adc_oe_n_q <= 1'b0;
               end
            end
            ST_READ: begin
               if (oe_cnt_q == 4'd0) begin
                  state_q    <= ST_IDLE;
                  adc_oe_n_q <= 1'b1;
               end else begin
                  oe_cnt_q <= oe_cnt_q - 4'd1;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               adc_oe_n_q <= 1'b1;
            end
         endcase
      end
   end

   assign push_w     = (state_q == ST_READ) && (oe_cnt_q == 4'd0);
   assign read_ovf_w = (state_q == ST_READ) && eoc_fall_q;

   assign sample_valid = (count_q != '0);
   assign sample_data  = mem_q[rd_ptr_q];
   assign pop_w        = sample_valid && sample_ready;
   assign full_w       = (count_q == CW'(FIFO_DEPTH));
   assign wr_en_w      = push_w && (!full_w || pop_w);
   assign fifo_ovf_w   = push_w && full_w && !pop_w;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en_w) begin
            mem_q[wr_ptr_q] <= adc_data;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop_w) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({wr_en_w, pop_w})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // A set event in the same cycle as flag_clr keeps the flag high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
      end else if (read_ovf_w || fifo_ovf_w) begin
         overflow_q <= 1'b1;
      end else if (flag_clr) begin
         overflow_q <= 1'b0;
      end
   end

   assign adc_oe_n = adc_oe_n_q;
   assign overflow = overflow_q;

`ifdef ADC_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          start_q, armed_q, timeout_q;
   logic [TW-1:0] tmo_cnt_q;
   logic          start_rise_w, tmo_set_w;

   assign start_rise_w = start && !start_q;
   assign tmo_set_w    = armed_q && !start_rise_w && !eoc_fall_q && (tmo_cnt_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_q   <= 1'b0;
         armed_q   <= 1'b0;
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         start_q <= start;
         if (start_rise_w) begin
            tmo_cnt_q <= TW'(TIMEOUT_CYCLES);
            armed_q   <= 1'b1;
         end else if (armed_q) begin
            if (eoc_fall_q || (tmo_cnt_q == '0)) begin
               armed_q <= 1'b0;
            end else begin
               tmo_cnt_q <= tmo_cnt_q - 1'b1;
            end
         end
         if (tmo_set_w) begin
            timeout_q <= 1'b1;
         end else if (flag_clr) begin
            timeout_q <= 1'b0;
         end
      end
   end

   assign timeout = timeout_q;
`else
   logic unused_start_w;
   assign unused_start_w = start;
   assign timeout        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adc_capture.sv
`default_nettype none
// ============================================================================
// Module : tb_adc_capture
// Directed bench for adc_capture with an edge-counting reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_adc_capture;

   localparam int OE    = 2;
   localparam int DEPTH = 4;
`ifdef ADC_TIMEOUT_EN
   localparam int TMO   = 64;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       eoc = 1'b1;
   logic [7:0] adc_data = 8'h00;
   logic       start = 1'b0;
   logic       flag_clr = 1'b0;
   logic       sample_ready = 1'b0;
   logic       adc_oe_n;
   logic [7:0] sample_data;
   logic       sample_valid;
   logic       overflow;
   logic       timeout;

   int checks = 0;
   int failures = 0;

   adc_capture #(
      .DATA_W(8), .OE_CYCLES(OE), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(64)
   ) dut (
      .clk(clk), .rst_n(rst_n), .eoc(eoc), .adc_data(adc_data),
      .start(start), .flag_clr(flag_clr), .adc_oe_n(adc_oe_n),
      .sample_data(sample_data), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .overflow(overflow), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each EOC fall sampled at edge g becomes a read request at
   // edge g+3; a request is refused while a read is busy, and an accepted one
   // pushes the word on edge request+OE.
   int         edge_no = 0;
   logic       m_prev_eoc = 1'b1;
   logic       m_prev_start = 1'b0;
   int         act_q[$];
   logic       m_busy = 1'b0;
   int         m_push_edge = 0;
   logic [7:0] m_fifo[$];
   logic       m_ovf = 1'b0;
   logic       m_tmo = 1'b0;
`ifdef ADC_TIMEOUT_EN
   logic       m_armed = 1'b0;
   int         m_tmo_edge = 0;
`endif

   task automatic model_reset();
      edge_no      = 0;
      m_prev_eoc   = 1'b1;
      m_prev_start = 1'b0;
      act_q.delete();
      m_busy       = 1'b0;
      m_fifo.delete();
      m_ovf        = 1'b0;
      m_tmo        = 1'b0;
`ifdef ADC_TIMEOUT_EN
      m_armed      = 1'b0;
`endif
   endtask

   // Called between edges: predicts the state after the coming rising edge
   // from the inputs that edge will sample.
   task automatic model_advance();
      int   n;
      logic fall, act, pop, push, full, ovf_set, tset;
      n       = edge_no + 1;
      edge_no = n;
      fall    = m_prev_eoc && !eoc;
      m_prev_eoc = eoc;
      if (fall) act_q.push_back(n + 3);
      act = (act_q.size() > 0) && (act_q[0] == n);
      if (act) void'(act_q.pop_front());
      pop     = (m_fifo.size() > 0) && sample_ready;
      full    = (m_fifo.size() == DEPTH);
      push    = m_busy && (m_push_edge == n);
      ovf_set = 1'b0;
      tset    = 1'b0;
      if (act && m_busy) ovf_set = 1'b1;
      if (push) m_busy = 1'b0;
      if (act && !ovf_set) begin
         m_busy      = 1'b1;
         m_push_edge = n + OE;
      end
      if (pop) void'(m_fifo.pop_front());
      if (push) begin
         if (full && !pop) ovf_set = 1'b1;
         else m_fifo.push_back(adc_data);
      end
      m_ovf = ovf_set ? 1'b1 : (flag_clr ? 1'b0 : m_ovf);
`ifdef ADC_TIMEOUT_EN
      if (start && !m_prev_start) begin
         m_armed    = 1'b1;
         m_tmo_edge = n + TMO + 1;
      end else if (m_armed) begin
         if (act) m_armed = 1'b0;
         else if (n == m_tmo_edge) begin
            tset    = 1'b1;
            m_armed = 1'b0;
         end
      end
`endif
      m_tmo = tset ? 1'b1 : (flag_clr ? 1'b0 : m_tmo);
      m_prev_start = start;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) model_reset();
         chk("model_oe_n", {31'd0, adc_oe_n}, {31'd0, !m_busy});
         chk("model_valid", {31'd0, sample_valid}, {31'd0, m_fifo.size() != 0});
         if (m_fifo.size() != 0) chk("model_data", {24'd0, sample_data}, {24'd0, m_fifo[0]});
         chk("model_overflow", {31'd0, overflow}, {31'd0, m_ovf});
         chk("model_timeout", {31'd0, timeout}, {31'd0, m_tmo});
         if (rst_n) model_advance();
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic eoc_event(input logic [7:0] d);
      eoc      = 1'b0;
      adc_data = d;
      step();
      eoc = 1'b1;
      repeat (7) step();
   endtask

   initial begin
      logic [7:0] exp3 [4];
      repeat (3) step();
      chk("rst_oe_n", {31'd0, adc_oe_n}, 32'd1);
      chk("rst_valid", {31'd0, sample_valid}, 32'd0);
      chk("rst_data", {24'd0, sample_data}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      chk("rst_timeout", {31'd0, timeout}, 32'd0);
      rst_n = 1'b1;
      repeat (2) step();

      // single read: strobe low after edges 3 and 4, word valid after edge 5
      eoc = 1'b0; adc_data = 8'hA5;
      step();
      eoc = 1'b1;
      repeat (3) step();
      chk("t1_oe_edge3", {31'd0, adc_oe_n}, 32'd0);
      step();
      chk("t1_oe_edge4", {31'd0, adc_oe_n}, 32'd0);
      chk("t1_valid_edge4", {31'd0, sample_valid}, 32'd0);
      step();
      chk("t1_oe_edge5", {31'd0, adc_oe_n}, 32'd1);
      chk("t1_valid_edge5", {31'd0, sample_valid}, 32'd1);
      chk("t1_data", {24'd0, sample_data}, 32'hA5);
      chk("t1_overflow", {31'd0, overflow}, 32'd0);
      sample_ready = 1'b1;
      step();
      chk("t1_drained", {31'd0, sample_valid}, 32'd0);
      sample_ready = 1'b0;

      // five samples into a four-entry FIFO
      for (int i = 1; i <= 5; i++) eoc_event(8'(i));
      chk("t2_overflow", {31'd0, overflow}, 32'd1);
      sample_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("t2_pop_data", {24'd0, sample_data}, i);
         step();
      end
      chk("t2_empty", {31'd0, sample_valid}, 32'd0);
      sample_ready = 1'b0;
      flag_clr = 1'b1;
      step();
      flag_clr = 1'b0;
      chk("t2_flag_clr", {31'd0, overflow}, 32'd0);

      // full FIFO, pop coincides with the push edge
      for (int i = 1; i <= 4; i++) eoc_event(8'(8'h10 + i));
      chk("t3_full_no_ovf", {31'd0, overflow}, 32'd0);
      eoc = 1'b0; adc_data = 8'h15;
      step();
      eoc = 1'b1;
      repeat (4) step();
      sample_ready = 1'b1;
      step();
      sample_ready = 1'b0;
      chk("t3_overflow", {31'd0, overflow}, 32'd0);
      chk("t3_head", {24'd0, sample_data}, 32'h12);
      step();
      exp3[0] = 8'h12; exp3[1] = 8'h13; exp3[2] = 8'h14; exp3[3] = 8'h15;
      sample_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t3_pop_data", {24'd0, sample_data}, {24'd0, exp3[i]});
         step();
      end
      chk("t3_empty", {31'd0, sample_valid}, 32'd0);
      sample_ready = 1'b0;

      // second EOC fall arrives while the read is still in progress
      eoc = 1'b0; adc_data = 8'h77;
      step();
      eoc = 1'b1;
      step();
      eoc = 1'b0;
      step();
      eoc = 1'b1;
      repeat (8) step();
      chk("t4_overflow", {31'd0, overflow}, 32'd1);
      chk("t4_data", {24'd0, sample_data}, 32'h77);
      sample_ready = 1'b1;
      step();
      chk("t4_one_sample", {31'd0, sample_valid}, 32'd0);
      sample_ready = 1'b0;
      flag_clr = 1'b1;
      step();
      flag_clr = 1'b0;
      chk("t4_flag_clr", {31'd0, overflow}, 32'd0);

      // watchdog: no EOC, then EOC well inside the window
      sample_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (70) step();
`ifdef ADC_TIMEOUT_EN
      chk("t5_timeout_set", {31'd0, timeout}, 32'd1);
`else
      chk("t5_timeout_absent", {31'd0, timeout}, 32'd0);
`endif
      flag_clr = 1'b1;
      step();
      flag_clr = 1'b0;
      chk("t5_timeout_clr", {31'd0, timeout}, 32'd0);
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (29) step();
      eoc_event(8'h3C);
      repeat (70) step();
      chk("t5_timeout_quiet", {31'd0, timeout}, 32'd0);
      sample_ready = 1'b0;

      // reset in the middle of a read
      eoc_event(8'h66);
      eoc = 1'b0; adc_data = 8'h99;
      step();
      eoc = 1'b1;
      repeat (3) step();
      chk("t6_oe_before", {31'd0, adc_oe_n}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("t6_oe_async", {31'd0, adc_oe_n}, 32'd1);
      chk("t6_valid", {31'd0, sample_valid}, 32'd0);
      chk("t6_data", {24'd0, sample_data}, 32'd0);
      chk("t6_overflow", {31'd0, overflow}, 32'd0);
      step();
      step();
      rst_n = 1'b1;
      repeat (10) step();
      chk("t6_no_sample", {31'd0, sample_valid}, 32'd0);
      chk("t6_oe_idle", {31'd0, adc_oe_n}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
